axil_ram_slave: RTL and testbench
=================================

AXIL_RAM_SLAVE -- requirements
Module: axil_ram_slave

Interface
REQ-001 The block SHALL be parametrised as follows:
- DATA_W, 32: data bus width in bits; legal values 8, 16, 32, 64.
- ADDR_W, 12: byte-address width.
- DEPTH, 1024: number of DATA_W-bit words; DEPTH <= 2^(ADDR_W - log2(DATA_W/8)).

REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- ACLK, in, 1: single clock.
- ARESETN, in, 1: reset, asynchronous, active-low.
- AWADDR, in, ADDR_W: write byte address.
- AWVALID, in, 1; AWREADY, out, 1: write-address handshake.
- WDATA, in, DATA_W: write data.
- WSTRB, in, DATA_W/8: byte enables.
- WVALID, in, 1; WREADY, out, 1: write-data handshake.
- BRESP, out, 2; BVALID, out, 1; BREADY, in, 1: write response.
- ARADDR, in, ADDR_W: read byte address.
- ARVALID, in, 1; ARREADY, out, 1: read-address handshake.
- RDATA, out, DATA_W; RRESP, out, 2; RVALID, out, 1; RREADY, in, 1: read data and response.

Function
REQ-003 Word index SHALL be ADDR[ADDR_W-1:log2(DATA_W/8)]; the low byte-offset bits SHALL be ignored.
REQ-004 An index >= DEPTH SHALL be out of range: response SLVERR (2'b10), no memory write, RDATA = 0. In-range accesses SHALL respond OKAY (2'b00).
REQ-005 The write FSM SHALL have states WR_IDLE, WR_MEM and WR_RESP.
REQ-006 In WR_IDLE, AWREADY and WREADY SHALL each be high until their own channel's handshake, then drop. AW and W SHALL be accepted in either order or in the same cycle, and each SHALL be latched internally.
REQ-007 When both AW and W are latched, the FSM SHALL enter WR_MEM and perform a one-cycle RAM write of the bytes where WSTRB[i]=1; an all-zero WSTRB SHALL write nothing and respond OKAY.
REQ-008 From WR_MEM the FSM SHALL enter WR_RESP with BVALID=1. BVALID and BRESP SHALL hold stable until BREADY=1, then return to WR_IDLE with AWREADY=WREADY=1 on the next cycle.
REQ-009 Write latency: if the later of the AW/W handshakes is at cycle N, BVALID SHALL rise at N+2 when there is no stall (REQ-012).
REQ-010 The read FSM SHALL have states RD_IDLE (ARREADY=1), RD_MEM and RD_RESP. An AR handshake SHALL register the address; RD_MEM SHALL issue the RAM read; RD_RESP SHALL drive RVALID=1 with RDATA/RRESP stable until RREADY=1, then return to RD_IDLE.
REQ-011 Read latency: an AR handshake at cycle N SHALL produce RVALID at N+2 when there is no stall.
REQ-012 The RAM SHALL be single-port. If WR_MEM and RD_MEM coincide, the write SHALL proceed and the read SHALL stall in RD_MEM for one cycle. A read to the same word SHALL return the newly written data.
REQ-013 At most one write and one read SHALL be outstanding; the read and write paths SHALL otherwise run concurrently.
REQ-014 The block SHALL not drop or reissue a response while xREADY is low. Back-to-back transactions SHALL sustain one write per 3 cycles and one read per 3 cycles with READY held high.

Reset
REQ-015 ARESETN low SHALL asynchronously force both FSMs to IDLE and clear all internal latches.
REQ-016 Output values during reset SHALL be: AWREADY=WREADY=ARREADY=0, BVALID=RVALID=0, BRESP=RRESP=2'b00, RDATA=0.
REQ-017 READY outputs SHALL rise on the first ACLK edge after ARESETN deasserts.
REQ-018 A reset mid-transaction SHALL abandon that transaction with no response; memory contents SHALL not be cleared. A RAM write already committed SHALL persist.

Structure
REQ-019 Package axil_pkg SHALL hold the RESP_OKAY/RESP_SLVERR constants and the write/read FSM state encodings.
REQ-020 Storage SHALL be the sub-module axil_bram_be: a single-port, DATA_W x DEPTH RAM with per-byte write enables and 1-cycle synchronous read, which is not reset.

Verification
REQ-021 Bench scenario, AW before W: AW 0x010 at cycle 0, W 0xDEADBEEF/WSTRB=0xF at cycle 3 -> BVALID at cycle 5, BRESP=00; a read of 0x010 returns 0xDEADBEEF, OKAY.
REQ-022 Bench scenario, partial strobe: word 0x020 holds 0x11223344; write 0xAABBCCDD with WSTRB=0x5 -> a read returns 0x11BB33DD.
REQ-023 Bench scenario, out of range (DEPTH=1024, DATA_W=32): write and then read at 0x1000 -> BRESP=10, RRESP=10, RDATA=0; word 0 is unchanged.
REQ-024 Bench scenario, collision: the AW/W and AR handshakes to 0x040 land in the same cycle with WDATA=0x5A5A5A5A -> BVALID at N+2, RVALID at N+3, RDATA=0x5A5A5A5A.
REQ-025 Bench scenario, backpressure: BREADY and RREADY held low for 10 cycles -> BVALID/RVALID and their data are stable throughout, and no new AW/AR is accepted.
REQ-026 Bench scenario, mid-transaction reset: ARESETN pulsed low while in WR_RESP -> BVALID drops immediately, READYs are 0 during reset and rise one cycle after release, and previously written data still reads back.

Source files
------------

// File: rtl/axil_ram_slave_pkg.sv
// Shared definitions for the AXI4-Lite RAM slave: response codes,
// write/read FSM state encodings and a small response helper.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_MEM  = 2'd1,
    WR_RESP = 2'd2
  } wr_state_t;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_MEM  = 2'd1,
    RD_RESP = 2'd2
  } rd_state_t;

  function automatic logic [1:0] resp_for(input logic err);
    return err ? RESP_SLVERR : RESP_OKAY;
  endfunction

endpackage

// File: rtl/axil_ram_slave_if.sv
// AXI4-Lite bus bundle. The master modport is the initiator side, the
// slave modport is what axil_ram_slave presents.
interface axil_ram_slave_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
);

  logic [ADDR_W-1:0]   AWADDR;
  logic                AWVALID;
  logic                AWREADY;
  logic [DATA_W-1:0]   WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic                WVALID;
  logic                WREADY;
  logic [1:0]          BRESP;
  logic                BVALID;
  logic                BREADY;
  logic [ADDR_W-1:0]   ARADDR;
  logic                ARVALID;
  logic                ARREADY;
  logic [DATA_W-1:0]   RDATA;
  logic [1:0]          RRESP;
  logic                RVALID;
  logic                RREADY;

  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
           ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
           ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

endinterface

// File: rtl/axil_ram_slave_bram.sv
// Single-port DATA_W x DEPTH RAM with per-byte write enables and a
// registered (1-cycle) read. Contents and read register are never reset.
module axil_bram_be #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 1024,
  parameter int WORD_AW = 10
) (
  input  logic                clk,
  input  logic                rd_en,
  input  logic [DATA_W/8-1:0] we,
  input  logic [WORD_AW-1:0]  addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  // Byte-masked write and synchronous read through the one shared address
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (we[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
    end
    if (rd_en) rdata <= mem[addr];
  end

endmodule

// File: rtl/axil_ram_slave.sv
// AXI4-Lite slave in front of a single-port byte-enabled RAM. Independent
// write and read FSMs share the RAM port; a write in WR_MEM wins and a
// coinciding read waits one cycle in RD_MEM, so it sees the new data.
module axil_ram_slave
  import axil_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 1024
) (
  input logic             ACLK,
  input logic             ARESETN,
  axil_ram_slave_if.slave bus
);

  localparam int NB     = DATA_W / 8;
  localparam int OFFS   = $clog2(NB);
  localparam int IDX_W  = ADDR_W - OFFS;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W:0] DEPTH_L = (IDX_W + 1)'(DEPTH);

  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;

  logic              live;
  logic              aw_held, w_held;
  logic [IDX_W-1:0]  aw_idx, ar_idx;
  logic [DATA_W-1:0] w_data;
  logic [NB-1:0]     w_strb;
  logic              aw_hs, w_hs, ar_hs;
  logic              aw_err, ar_err;
  logic [NB-1:0]     ram_we;
  logic              ram_rd;
  logic [MEM_AW-1:0] ram_addr;
  logic [DATA_W-1:0] ram_rdata;

  assign bus.AWREADY = live && (wr_state == WR_IDLE) && !aw_held;
  assign bus.WREADY  = live && (wr_state == WR_IDLE) && !w_held;
  assign bus.ARREADY = live && (rd_state == RD_IDLE);

  assign aw_hs = bus.AWVALID && bus.AWREADY;
  assign w_hs  = bus.WVALID  && bus.WREADY;
  assign ar_hs = bus.ARVALID && bus.ARREADY;

  assign aw_err = ({1'b0, aw_idx} >= DEPTH_L);
  assign ar_err = ({1'b0, ar_idx} >= DEPTH_L);

  assign ram_addr = (wr_state == WR_MEM) ? aw_idx[MEM_AW-1:0] : ar_idx[MEM_AW-1:0];

  // READYs stay low through reset and rise on the first edge after release
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) live <= 1'b0;
    else          live <= 1'b1;
  end

  // Write FSM state register
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) wr_state <= WR_IDLE;
    else          wr_state <= wr_next;
  end

  // Write FSM next state, RAM write strobes and B channel outputs
  always_comb begin
    wr_next    = wr_state;
    ram_we     = '0;
    bus.BVALID = 1'b0;
    bus.BRESP  = RESP_OKAY;
    unique case (wr_state)
      WR_IDLE: begin
        if ((aw_held || aw_hs) && (w_held || w_hs)) wr_next = WR_MEM;
      end
      WR_MEM: begin
        ram_we  = aw_err ? '0 : w_strb;
        wr_next = WR_RESP;
      end
      WR_RESP: begin
        bus.BVALID = 1'b1;
        bus.BRESP  = resp_for(aw_err);
        if (bus.BREADY) wr_next = WR_IDLE;
      end
      default: wr_next = WR_IDLE;
    endcase
  end

  // Capture AW and W independently; held flags clear once both are in
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_idx  <= '0;
      w_data  <= '0;
      w_strb  <= '0;
      aw_held <= 1'b0;
      w_held  <= 1'b0;
    end else begin
      if (aw_hs) aw_idx <= bus.AWADDR[ADDR_W-1:OFFS];
      if (w_hs) begin
        w_data <= bus.WDATA;
        w_strb <= bus.WSTRB;
      end
      aw_held <= (wr_state == WR_IDLE) && (wr_next == WR_IDLE) && (aw_held || aw_hs);
      w_held  <= (wr_state == WR_IDLE) && (wr_next == WR_IDLE) && (w_held || w_hs);
    end
  end

  // Read FSM state register
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) rd_state <= RD_IDLE;
    else          rd_state <= rd_next;
  end

  // Read FSM next state, RAM read issue (yielding to a write) and R outputs
  always_comb begin
    rd_next    = rd_state;
    ram_rd     = 1'b0;
    bus.RVALID = 1'b0;
    bus.RRESP  = RESP_OKAY;
    bus.RDATA  = '0;
    unique case (rd_state)
      RD_IDLE: begin
        if (ar_hs) rd_next = RD_MEM;
      end
      RD_MEM: begin
        if (wr_state != WR_MEM) begin
          ram_rd  = !ar_err;
          rd_next = RD_RESP;
        end
      end
      RD_RESP: begin
        bus.RVALID = 1'b1;
        bus.RRESP  = resp_for(ar_err);
        bus.RDATA  = ar_err ? '0 : ram_rdata;
        if (bus.RREADY) rd_next = RD_IDLE;
      end
      default: rd_next = RD_IDLE;
    endcase
  end

  // Register the read word index on the AR handshake
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)   ar_idx <= '0;
    else if (ar_hs) ar_idx <= bus.ARADDR[ADDR_W-1:OFFS];
  end

  axil_bram_be #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .WORD_AW (MEM_AW)
  ) u_bram (
    .clk   (ACLK),
    .rd_en (ram_rd),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (w_data),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_axil_ram_slave.sv
// Directed bench for axil_ram_slave: a vector table of single write/read
// transactions plus hand-written sequences for ordering, collision,
// backpressure and mid-transaction reset.
module tb_axil_ram_slave;
  import axil_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 13;
  localparam int DEPTH  = 1024;
  localparam int NV     = 17;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [3:0]        strb;
    logic [1:0]        resp;
    logic [DATA_W-1:0] rdata;
  } vec_t;

  logic ACLK = 1'b0;
  logic ARESETN = 1'b0;
  int checks = 0;
  int errors = 0;
  vec_t vecs [NV];

  axil_ram_slave_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  axil_ram_slave #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .bus     (bus)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  task automatic wait_b(output logic [1:0] resp, output int lat);
    resp = 2'b11;
    lat  = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge ACLK);
      if (bus.BVALID) begin
        resp = bus.BRESP;
        lat  = k;
        break;
      end
    end
    if (lat > 0 && bus.BREADY) begin
      @(posedge ACLK); #1;
    end
  endtask

  task automatic write_txn(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                           input logic [3:0] strb, output logic [1:0] resp, output int lat);
    bit aw_done = 0;
    bit w_done = 0;
    bit aw_now, w_now;
    resp = 2'b11;
    lat  = 0;
    bus.AWADDR = addr; bus.AWVALID = 1'b1;
    bus.WDATA = data; bus.WSTRB = strb; bus.WVALID = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK);
      aw_now = bus.AWVALID && bus.AWREADY;
      w_now  = bus.WVALID && bus.WREADY;
      @(posedge ACLK); #1;
      if (aw_now) begin bus.AWVALID = 1'b0; aw_done = 1; end
      if (w_now)  begin bus.WVALID = 1'b0;  w_done = 1;  end
      if (aw_done && w_done) break;
    end
    bus.AWVALID = 1'b0;
    bus.WVALID  = 1'b0;
    if (aw_done && w_done) wait_b(resp, lat);
  endtask

  task automatic read_txn(input logic [ADDR_W-1:0] addr, output logic [DATA_W-1:0] data,
                          output logic [1:0] resp, output int lat);
    bit done = 0;
    data = '0;
    resp = 2'b11;
    lat  = 0;
    bus.ARADDR = addr; bus.ARVALID = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK);
      done = bus.ARREADY;
      @(posedge ACLK); #1;
      if (done) break;
    end
    bus.ARVALID = 1'b0;
    if (done) begin
      for (int k = 1; k <= 20; k++) begin
        @(negedge ACLK);
        if (bus.RVALID) begin
          data = bus.RDATA;
          resp = bus.RRESP;
          lat  = k;
          break;
        end
      end
      if (lat > 0 && bus.RREADY) begin
        @(posedge ACLK); #1;
      end
    end
  endtask

  task automatic apply_stimulus(input vec_t v, input int idx);
    logic [1:0] resp;
    logic [DATA_W-1:0] data;
    int lat;
    if (v.wr) begin
      write_txn(v.addr, v.data, v.strb, resp, lat);
      check_output($sformatf("vec%0d bresp", idx), resp, v.resp);
      check_output($sformatf("vec%0d b latency", idx), lat, 2);
    end else begin
      read_txn(v.addr, data, resp, lat);
      check_output($sformatf("vec%0d rresp", idx), resp, v.resp);
      check_output($sformatf("vec%0d rdata", idx), data, v.rdata);
      check_output($sformatf("vec%0d r latency", idx), lat, 2);
    end
  endtask

  initial begin
    logic [1:0] resp, rr;
    logic [DATA_W-1:0] rd;
    int lat, b_lat, r_lat;

    vecs[0]  = '{1'b1, 13'h0000, 32'hCAFEF00D, 4'hF, RESP_OKAY,   32'h0};
    vecs[1]  = '{1'b0, 13'h0000, 32'h0,        4'h0, RESP_OKAY,   32'hCAFEF00D};
    vecs[2]  = '{1'b1, 13'h0020, 32'h11223344, 4'hF, RESP_OKAY,   32'h0};
    vecs[3]  = '{1'b1, 13'h0020, 32'hAABBCCDD, 4'h5, RESP_OKAY,   32'h0};
    vecs[4]  = '{1'b0, 13'h0020, 32'h0,        4'h0, RESP_OKAY,   32'h11BB33DD};
    vecs[5]  = '{1'b0, 13'h0023, 32'h0,        4'h0, RESP_OKAY,   32'h11BB33DD};
    vecs[6]  = '{1'b1, 13'h0030, 32'h01020304, 4'hF, RESP_OKAY,   32'h0};
    vecs[7]  = '{1'b1, 13'h0030, 32'hFFFFFFFF, 4'h0, RESP_OKAY,   32'h0};
    vecs[8]  = '{1'b0, 13'h0030, 32'h0,        4'h0, RESP_OKAY,   32'h01020304};
    vecs[9]  = '{1'b1, 13'h1000, 32'h12345678, 4'hF, RESP_SLVERR, 32'h0};
    vecs[10] = '{1'b0, 13'h1000, 32'h0,        4'h0, RESP_SLVERR, 32'h0};
    vecs[11] = '{1'b0, 13'h0000, 32'h0,        4'h0, RESP_OKAY,   32'hCAFEF00D};
    vecs[12] = '{1'b1, 13'h0FFC, 32'h0BADC0DE, 4'hF, RESP_OKAY,   32'h0};
    vecs[13] = '{1'b0, 13'h0FFE, 32'h0,        4'h0, RESP_OKAY,   32'h0BADC0DE};
    vecs[14] = '{1'b1, 13'h1FFC, 32'h77777777, 4'hF, RESP_SLVERR, 32'h0};
    vecs[15] = '{1'b0, 13'h1FFC, 32'h0,        4'h0, RESP_SLVERR, 32'h0};
    vecs[16] = '{1'b1, 13'h0040, 32'h00000000, 4'hF, RESP_OKAY,   32'h0};

    bus.AWADDR = '0; bus.AWVALID = 1'b0;
    bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 1'b0;
    bus.BREADY = 1'b1;
    bus.ARADDR = '0; bus.ARVALID = 1'b0;
    bus.RREADY = 1'b1;

    // reset values and READY rise after release
    repeat (2) @(negedge ACLK);
    check_output("reset readys", {bus.AWREADY, bus.WREADY, bus.ARREADY}, 3'b000);
    check_output("reset valids", {bus.BVALID, bus.RVALID}, 2'b00);
    check_output("reset resps", {bus.BRESP, bus.RRESP}, 4'h0);
    check_output("reset rdata", bus.RDATA, 32'h0);
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    @(negedge ACLK);
    check_output("ready before first edge", {bus.AWREADY, bus.WREADY, bus.ARREADY}, 3'b000);
    @(negedge ACLK);
    check_output("ready after first edge", {bus.AWREADY, bus.WREADY, bus.ARREADY}, 3'b111);

    for (int i = 0; i < NV; i++) apply_stimulus(vecs[i], i);

    // AW at cycle 0, W at cycle 3, BVALID expected at cycle 5
    @(posedge ACLK); #1;
    bus.AWADDR = 13'h0010; bus.AWVALID = 1'b1;
    @(negedge ACLK);
    check_output("split aw ready", bus.AWREADY, 1'b1);
    @(posedge ACLK); #1;
    bus.AWVALID = 1'b0;
    @(negedge ACLK);
    check_output("split ready after aw", {bus.AWREADY, bus.WREADY}, 2'b01);
    @(posedge ACLK); #1;
    @(posedge ACLK); #1;
    bus.WDATA = 32'hDEADBEEF; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
    @(negedge ACLK);
    check_output("split w ready", bus.WREADY, 1'b1);
    @(posedge ACLK); #1;
    bus.WVALID = 1'b0;
    wait_b(resp, lat);
    check_output("split b latency", lat, 2);
    check_output("split bresp", resp, RESP_OKAY);
    read_txn(13'h0010, rd, rr, lat);
    check_output("split readback", rd, 32'hDEADBEEF);
    check_output("split rresp", rr, RESP_OKAY);

    // write and read of the same word handshake in the same cycle
    @(posedge ACLK); #1;
    bus.AWADDR = 13'h0040; bus.AWVALID = 1'b1;
    bus.WDATA = 32'h5A5A5A5A; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
    bus.ARADDR = 13'h0040; bus.ARVALID = 1'b1;
    @(negedge ACLK);
    check_output("coll readys", {bus.AWREADY, bus.WREADY, bus.ARREADY}, 3'b111);
    @(posedge ACLK); #1;
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
    b_lat = 0; r_lat = 0; rd = '0; rr = 2'b11;
    for (int k = 1; k <= 10; k++) begin
      @(negedge ACLK);
      if (bus.BVALID && b_lat == 0) b_lat = k;
      if (bus.RVALID && r_lat == 0) begin
        r_lat = k; rd = bus.RDATA; rr = bus.RRESP;
      end
      if (b_lat != 0 && r_lat != 0) break;
    end
    @(posedge ACLK); #1;
    check_output("coll b latency", b_lat, 2);
    check_output("coll r latency", r_lat, 3);
    check_output("coll rdata", rd, 32'h5A5A5A5A);
    check_output("coll rresp", rr, RESP_OKAY);

    // backpressure: both responses held for 10 cycles, no new address taken
    bus.BREADY = 1'b0; bus.RREADY = 1'b0;
    bus.AWADDR = 13'h0050; bus.AWVALID = 1'b1;
    bus.WDATA = 32'h13579BDF; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
    bus.ARADDR = 13'h0020; bus.ARVALID = 1'b1;
    @(negedge ACLK);
    @(posedge ACLK); #1;
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge ACLK);
      if (bus.BVALID && bus.RVALID) break;
    end
    @(posedge ACLK); #1;
    bus.AWADDR = 13'h0060; bus.AWVALID = 1'b1;
    bus.WDATA = 32'hFFFF0000; bus.WVALID = 1'b1;
    bus.ARADDR = 13'h0000; bus.ARVALID = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge ACLK);
      check_output($sformatf("bp bvalid c%0d", k), bus.BVALID, 1'b1);
      check_output($sformatf("bp bresp c%0d", k), bus.BRESP, RESP_OKAY);
      check_output($sformatf("bp rvalid c%0d", k), bus.RVALID, 1'b1);
      check_output($sformatf("bp rdata c%0d", k), bus.RDATA, 32'h11BB33DD);
      check_output($sformatf("bp readys c%0d", k), {bus.AWREADY, bus.WREADY, bus.ARREADY}, 3'b000);
      @(posedge ACLK); #1;
    end
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
    bus.BREADY = 1'b1; bus.RREADY = 1'b1;
    @(posedge ACLK); #1;
    @(negedge ACLK);
    check_output("bp released", {bus.BVALID, bus.RVALID}, 2'b00);
    read_txn(13'h0050, rd, rr, lat);
    check_output("bp readback", rd, 32'h13579BDF);

    // reset while the write sits in WR_RESP
    bus.BREADY = 1'b0;
    write_txn(13'h0060, 32'h0F0F0F0F, 4'hF, resp, lat);
    check_output("rst b latency", lat, 2);
    @(posedge ACLK); #1;
    check_output("rst bvalid held", bus.BVALID, 1'b1);
    ARESETN = 1'b0;
    #1;
    check_output("rst bvalid drop", bus.BVALID, 1'b0);
    check_output("rst readys low", {bus.AWREADY, bus.WREADY, bus.ARREADY}, 3'b000);
    @(negedge ACLK);
    check_output("rst rdata", {bus.RVALID, bus.RDATA}, 33'h0);
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    bus.BREADY = 1'b1;
    @(negedge ACLK);
    check_output("rst readys before edge", {bus.AWREADY, bus.WREADY, bus.ARREADY}, 3'b000);
    @(negedge ACLK);
    check_output("rst readys after edge", {bus.AWREADY, bus.WREADY, bus.ARREADY}, 3'b111);
    check_output("rst no reissue", bus.BVALID, 1'b0);
    read_txn(13'h0060, rd, rr, lat);
    check_output("rst committed data", rd, 32'h0F0F0F0F);
    read_txn(13'h0010, rd, rr, lat);
    check_output("rst older data", rd, 32'hDEADBEEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
